// File: rtl/pll_phase_stepper.sv
`default_nettype none
// ============================================================================
// Module   : pll_phase_stepper
// Purpose  : Sequences optional PLL areset/clkswitch pulses followed by N
//            dynamic phase steps using a divided scanclk handshake.
// Revision : 1.0
// ============================================================================
module pll_phase_stepper #(
    parameter int STEP_W     = 8,
    parameter int SCAN_DIV   = 16,
    parameter int HOLD_HP    = 6,
    parameter int TIMEOUT_HP = 100,
    parameter int RST_CYC    = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              update,
    input  logic              do_areset,
    input  logic              pll_clksrc,
    input  logic [2:0]        counter_sel,
    input  logic              direction,
    input  logic [STEP_W-1:0] pll_phase,
    input  logic              phase_done,
    output logic              areset,
    output logic              clkswitch,
    output logic              phasestep,
    output logic              scanclk,
    output logic [2:0]        phasecounterselect,
    output logic              phaseupdown,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [STEP_W-1:0] steps_done
);

    localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_hp_w  = $clog2(TIMEOUT_HP + 1);
    localparam int c_cyc_w = $clog2(RST_CYC + 1);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_hp_w-1:0]  c_hold_hp  = c_hp_w'(HOLD_HP);
    localparam logic [c_hp_w-1:0]  c_ack_hp   = c_hp_w'(HOLD_HP + 2);
    localparam logic [c_hp_w-1:0]  c_tmo_hp   = c_hp_w'(TIMEOUT_HP);
    localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARESET = 3'd1,
        S_CLKSW  = 3'd2,
        S_SETUP  = 3'd3,
        S_STEP   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t              state_q;
    logic [c_cyc_w-1:0]  cnt_q;
    logic [c_div_w-1:0]  div_q;
    logic [c_hp_w-1:0]   hp_q;
    logic [c_hp_w-1:0]   hp_d;
    logic [2:0]          sel_q;
    logic                dir_q;
    logic                clksrc_q;
    logic [STEP_W-1:0]   n_q;
    logic [STEP_W-1:0]   steps_q;
    logic                areset_q;
    logic                clksw_q;
    logic                pstep_q;
    logic                sclk_q;
    logic [2:0]          pcs_q;
    logic                pud_q;
    logic                busy_q;
    logic                done_q;
    logic                tmo_q;
    logic                w_tick;

    assign hp_d   = hp_q + 1'b1;
    assign w_tick = (div_q == c_div_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            hp_q     <= '0;
            sel_q    <= 3'b000;
            dir_q    <= 1'b1;
            clksrc_q <= 1'b0;
            n_q      <= '0;
            steps_q  <= '0;
            areset_q <= 1'b0;
            clksw_q  <= 1'b0;
            pstep_q  <= 1'b0;
            sclk_q   <= 1'b0;
            pcs_q    <= 3'b000;
            pud_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (update) begin
                        sel_q    <= counter_sel;
                        dir_q    <= direction;
                        clksrc_q <= pll_clksrc;
                        n_q      <= pll_phase;
                        steps_q  <= '0;
                        tmo_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        if (do_areset) begin
                            areset_q <= 1'b1;
                            state_q  <= S_ARESET;
                        end else if (pll_clksrc) begin
                            clksw_q <= 1'b1;
                            state_q <= S_CLKSW;
                        end else begin
                            state_q <= S_SETUP;
                        end
                    end
                end
                S_ARESET: begin
                    if (cnt_q == c_cyc_last) begin
                        areset_q <= 1'b0;
                        cnt_q    <= '0;
                        if (clksrc_q) begin
                            clksw_q <= 1'b1;
                            state_q <= S_CLKSW;
                        end else begin
                            state_q <= S_SETUP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CLKSW: begin
                    if (cnt_q == c_cyc_last) begin
                        clksw_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_SETUP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SETUP: begin
                    if (steps_q == n_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        pcs_q   <= sel_q;
                        pud_q   <= dir_q;
                        sclk_q  <= 1'b0;
                        pstep_q <= 1'b1;
                        hp_q    <= '0;
                        div_q   <= '0;
                        state_q <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (w_tick) begin
                        div_q <= '0;
                        if (hp_d == c_hold_hp) begin
                            pstep_q <= 1'b0;
                        end
                        // Acknowledge wins over timeout when both land on the same toggle.
                        if ((hp_d >= c_ack_hp) && phase_done) begin
                            steps_q <= steps_q + 1'b1;
                            sclk_q  <= 1'b0;
                            state_q <= S_SETUP;
                        end else if (hp_d == c_tmo_hp) begin
                            tmo_q   <= 1'b1;
                            sclk_q  <= 1'b0;
                            pstep_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            sclk_q <= ~sclk_q;
                            hp_q   <= hp_d;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign areset             = areset_q;
    assign clkswitch          = clksw_q;
    assign phasestep          = pstep_q;
    assign scanclk            = sclk_q;
    assign phasecounterselect = pcs_q;
    assign phaseupdown        = pud_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign timeout_err        = tmo_q;
    assign steps_done         = steps_q;

endmodule
`default_nettype wire

// File: doc/pll_phase_stepper.md
PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 SHALL have parameter STEP_W, default 8, width of step-count input/output.
REQ-002 SHALL have parameter SCAN_DIV, default 16, clk cycles per scanclk half-period (>=2).
REQ-003 SHALL have parameter HOLD_HP, default 6, scanclk half-periods phasestep stays asserted.
REQ-004 SHALL have parameter TIMEOUT_HP, default 100, max half-periods per step before abort (> HOLD_HP+2).
REQ-005 SHALL have parameter RST_CYC, default 8, clk cycles for the areset and clkswitch pulses.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rstn  in  1  asynchronous, active-low reset.
REQ-008 update  in  1  one-cycle request, sampled only in IDLE.
REQ-009 do_areset  in  1  issue areset pulse before stepping.
REQ-010 pll_clksrc  in  1  issue clkswitch pulse after areset phase.
REQ-011 counter_sel  in  3  PLL counter select (000 all, 001 M, 010..110 C0..C4).
REQ-012 direction  in  1  1 = up, 0 = down.
REQ-013 pll_phase  in  STEP_W  number of steps N.
REQ-014 phase_done  in  1  PLL phase-step acknowledge (synchronised to clk externally).
REQ-015 areset, clkswitch, phasestep, scanclk  out  1 each  PLL control.
REQ-016 phasecounterselect  out  3;  phaseupdown  out  1.
REQ-017 busy  out  1;  done  out  1 (one-cycle pulse);  timeout_err  out  1 (sticky).
REQ-018 steps_done  out  STEP_W  steps completed in current/last request.

Function
REQ-019 States SHALL be IDLE, ARESET, CLKSW, SETUP, STEP, FINISH.
REQ-020 IDLE+update SHALL latch all request inputs, clear steps_done and timeout_err, assert busy next cycle; go ARESET if do_areset, else CLKSW if pll_clksrc, else SETUP.
REQ-021 update outside IDLE SHALL be ignored; no queueing.
REQ-022 ARESET SHALL hold areset=1 exactly RST_CYC cycles, then go CLKSW if pll_clksrc latched, else SETUP.
REQ-023 CLKSW SHALL hold clkswitch=1 exactly RST_CYC cycles, then SETUP.
REQ-024 SETUP: if steps_done == N go FINISH (N=0 performs zero steps); else drive phasecounterselect/phaseupdown from latched values, scanclk=0, phasestep=1, clear half-period count h, go STEP.
REQ-025 STEP: every SCAN_DIV cycles SHALL toggle scanclk and increment h.
REQ-026 phasestep SHALL drop to 0 at the toggle where h reaches HOLD_HP.
REQ-027 At a toggle with h >= HOLD_HP+2 and phase_done=1, steps_done SHALL increment, scanclk forced 0, go SETUP.
REQ-028 At a toggle with h == TIMEOUT_HP and no completion, SHALL set timeout_err, force scanclk=0 and phasestep=0, go FINISH (remaining steps abandoned).
REQ-029 FINISH SHALL pulse done for exactly one cycle, deassert busy, return IDLE.
REQ-030 phasecounterselect and phaseupdown SHALL remain stable throughout STEP.
REQ-031 steps_done SHALL never exceed N; counters SHALL not wrap for N = 2^STEP_W-1.

Reset
REQ-032 rstn low SHALL immediately force: state IDLE, areset=0, clkswitch=0, phasestep=0, scanclk=0, phasecounterselect=000, phaseupdown=1, busy=0, done=0, timeout_err=0, steps_done=0.
REQ-033 Reset mid-operation SHALL abandon the request; after release block SHALL accept a new update next cycle.

Verification
REQ-034 do_areset=1, pll_clksrc=1, N=0 -> areset high 8 cycles, then clkswitch high 8 cycles, done pulse, steps_done=0, no phasestep.
REQ-035 N=3, direction=0, counter_sel=011, phase_done tied 1 -> exactly 3 phasestep pulses, each 6 half-periods (96 clk), phaseupdown=0, select=011, steps_done=3, done once.
REQ-036 N=2, phase_done never asserted -> timeout_err=1 after 100 half-periods of first step, steps_done=0, scanclk=0, done pulse.
REQ-037 update re-asserted while busy with different pll_phase -> ignored; original N completes unchanged.
REQ-038 rstn pulsed low mid-STEP with scanclk=1 -> all outputs at reset values asynchronously; subsequent N=1 request completes with steps_done=1.
